// File: rtl/seg7_capture_decoder_if.sv
// Segment capture port bundle: raw pattern and controls in, decoded digit handshake out.
interface seg7_capture_decoder_if #(
   parameter int ERR_W = 8
);
   logic [6:0]       seg_in;
   logic             sample_en;
   logic             out_ready;
   logic             out_valid;
   logic [3:0]       out_nibble;
   logic             out_err;
   logic             stable;
   logic [ERR_W-1:0] err_count;

   modport master (
      output seg_in, sample_en, out_ready,
      input  out_valid, out_nibble, out_err, stable, err_count
   );

   modport slave (
      input  seg_in, sample_en, out_ready,
      output out_valid, out_nibble, out_err, stable, err_count
   );
endinterface

// File: rtl/seg7_capture_decoder.sv
// Recovers hex digits from an active-low 7-segment pattern; result appears STABLE_CYCLES+1 edges after a change.
// Each stable pattern is offered once and held on out_valid until out_ready; illegal patterns are flagged and counted.
module seg7_capture_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int ERR_W         = 8
) (
   input logic                   clk,
   input logic                   reset,
   seg7_capture_decoder_if.slave bus
);
   localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
   localparam logic [6:0] BLANK   = 7'h7F;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EMIT     = 2'd1,
      WAIT_CHG = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [6:0]       p;
   logic [3:0]       cnt;
   logic             chg;
   logic [3:0]       nib_q;
   logic             err_q;
   logic [ERR_W-1:0] err_cnt_q;
   logic             stable_w;
   logic [3:0]       dec_nib;
   logic             dec_err;
   logic             capture;
   logic             handshake;

   assign stable_w = (cnt == CNT_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p   <= BLANK;
         cnt <= 4'd0;
      end else begin
         p <= bus.seg_in;
         if (bus.seg_in != p) begin
            cnt <= 4'd1;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   always_comb begin
      dec_nib = 4'h0;
      dec_err = 1'b0;
      case (p)
         7'b1000000: dec_nib = 4'h0;
         7'b1111001: dec_nib = 4'h1;
         7'b0100100: dec_nib = 4'h2;
         7'b0110000: dec_nib = 4'h3;
         7'b0011001: dec_nib = 4'h4;
         7'b0010010: dec_nib = 4'h5;
         7'b0000010: dec_nib = 4'h6;
         7'b1111000: dec_nib = 4'h7;
         7'b0000000: dec_nib = 4'h8;
         7'b0010000: dec_nib = 4'h9;
         7'b0001000: dec_nib = 4'hA;
         7'b0000011: dec_nib = 4'hB;
         7'b1000110: dec_nib = 4'hC;
         7'b0100001: dec_nib = 4'hD;
         7'b0000110: dec_nib = 4'hE;
         7'b0001110: dec_nib = 4'hF;
         default:    dec_err = 1'b1;
      endcase
   end

   // chg remembers a pattern change seen while the result was still being offered,
   // so WAIT_CHG can leave even if the new pattern has already re-stabilised.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      handshake = 1'b0;
      case (state)
         IDLE: begin
            if (stable_w && bus.sample_en && (p != BLANK)) begin
               capture   = 1'b1;
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               handshake = 1'b1;
               state_nxt = WAIT_CHG;
            end
         end
         WAIT_CHG: begin
            if (!stable_w || chg) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nib_q     <= 4'h0;
         err_q     <= 1'b0;
         chg       <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         if (capture) begin
            nib_q <= dec_err ? 4'h0 : dec_nib;
            err_q <= dec_err;
            chg   <= 1'b0;
         end else if ((state == EMIT) && !stable_w) begin
            chg <= 1'b1;
         end
         if (handshake && err_q && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
         end
      end
   end

   assign bus.out_valid  = (state == EMIT);
   assign bus.out_nibble = nib_q;
   assign bus.out_err    = err_q;
   assign bus.stable     = stable_w;
   assign bus.err_count  = err_cnt_q;
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed and randomized checks of seg7_capture_decoder against a sample-history reference model.
module tb_seg7_capture_decoder;
   localparam int S     = 4;
   localparam int ERR_W = 8;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic clk;
   logic reset;

   seg7_capture_decoder_if #(.ERR_W(ERR_W)) bus ();

   seg7_capture_decoder #(.STABLE_CYCLES(S), .ERR_W(ERR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   int checks = 0;
   int errors = 0;

   // Reference model: history of sampled patterns plus the pending offer.
   logic [6:0] samples [$];
   int         run_id;
   int         cap_run;
   int         last_hs;
   int         edge_no;
   bit         m_busy;
   bit         m_stable;
   logic [3:0] m_nib;
   bit         m_err;
   int         m_errcnt;

   function automatic bit is_legal(input logic [6:0] v);
      bit r = 1'b0;
      for (int i = 0; i < 16; i++) if (seg_tab[i] == v) r = 1'b1;
      return r;
   endfunction

   function automatic logic [3:0] digit_of(input logic [6:0] v);
      logic [3:0] d = 4'h0;
      for (int i = 0; i < 16; i++) if (seg_tab[i] == v) d = 4'(i);
      return d;
   endfunction

   function automatic logic [6:0] rand_illegal();
      logic [6:0] v = 7'b1010101;
      for (int tries = 0; tries < 200; tries++) begin
         v = 7'($urandom_range(0, 127));
         if (!is_legal(v) && v != 7'h7F) break;
      end
      if (is_legal(v) || v == 7'h7F) v = 7'b1010101;
      return v;
   endfunction

   task automatic model_reset();
      samples.delete();
      run_id   = 0;
      cap_run  = -1;
      last_hs  = -10;
      edge_no  = 0;
      m_busy   = 1'b0;
      m_stable = 1'b0;
      m_nib    = 4'h0;
      m_err    = 1'b0;
      m_errcnt = 0;
   endtask

   // Advance the model by one clock edge using the inputs the DUT is about to sample.
   task automatic model_step();
      bit all_eq;
      logic [6:0] last;
      if (reset) begin
         model_reset();
         return;
      end
      last = (samples.size() > 0) ? samples[samples.size()-1] : 7'h7F;
      if (m_busy && bus.out_ready) begin
         m_busy  = 1'b0;
         last_hs = edge_no;
         if (m_err && m_errcnt < ERR_MAX) m_errcnt++;
      end else if (!m_busy && edge_no >= last_hs + 2 && m_stable && bus.sample_en
                   && last != 7'h7F && run_id != cap_run) begin
         m_busy  = 1'b1;
         m_err   = !is_legal(last);
         m_nib   = m_err ? 4'h0 : digit_of(last);
         cap_run = run_id;
      end
      if (samples.size() == 0 || bus.seg_in != last) run_id++;
      samples.push_back(bus.seg_in);
      if (samples.size() > 16) void'(samples.pop_front());
      all_eq = (samples.size() >= S);
      if (all_eq) begin
         for (int i = 1; i < S; i++)
            if (samples[samples.size()-1-i] != bus.seg_in) all_eq = 1'b0;
      end
      m_stable = all_eq;
      edge_no++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("valid", 32'(bus.out_valid), 32'(m_busy));
      chk("stable", 32'(bus.stable), 32'(m_stable));
      chk("errcnt", 32'(bus.err_count), 32'(m_errcnt));
      if (m_busy) begin
         chk("nibble", 32'(bus.out_nibble), 32'(m_nib));
         chk("err", 32'(bus.out_err), 32'(m_err));
      end
   endtask

   task automatic wait_valid(input int maxc, input string tag);
      int n = 0;
      while (!bus.out_valid && n < maxc) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.out_valid), 32'd1);
   endtask

   initial begin
      int nv;
      logic [3:0] seen_nib;
      int r;
      int hold;
      reset         = 1'b1;
      bus.seg_in    = 7'h7F;
      bus.sample_en = 1'b0;
      bus.out_ready = 1'b0;
      model_reset();
      tick();
      tick();
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_stable", 32'(bus.stable), 32'd0);
      chk("rst_errcnt", 32'(bus.err_count), 32'd0);
      chk("rst_nibble", 32'(bus.out_nibble), 32'd0);

      // 1: digit 2 appears at E4 and lasts one cycle with out_ready high
      reset         = 1'b0;
      bus.seg_in    = 7'b0100100;
      bus.sample_en = 1'b1;
      bus.out_ready = 1'b1;
      repeat (4) tick();
      chk("t1_early", 32'(bus.out_valid), 32'd0);
      tick();
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_nibble", 32'(bus.out_nibble), 32'h2);
      chk("t1_err", 32'(bus.out_err), 32'd0);
      tick();
      chk("t1_pulse", 32'(bus.out_valid), 32'd0);

      // 2: long hold of F emits once; change to 0 emits again
      bus.seg_in = 7'b0001110;
      nv = 0;
      seen_nib = 4'h0;
      repeat (20) begin
         tick();
         if (bus.out_valid) begin
            nv++;
            seen_nib = bus.out_nibble;
         end
      end
      chk("t2_once", 32'(nv), 32'd1);
      chk("t2_nib_f", 32'(seen_nib), 32'hF);
      bus.seg_in = 7'b1000000;
      wait_valid(20, "t2_wait0");
      chk("t2_nib_0", 32'(bus.out_nibble), 32'h0);
      tick();

      // 3: illegal patterns flag out_err and saturate err_count
      bus.seg_in = 7'b1010101;
      wait_valid(20, "t3_wait");
      chk("t3_err", 32'(bus.out_err), 32'd1);
      chk("t3_nib", 32'(bus.out_nibble), 32'd0);
      tick();
      chk("t3_cnt1", 32'(bus.err_count), 32'd1);
      for (int i = 1; i < 300; i++) begin
         bus.seg_in = 7'h7F;
         tick();
         tick();
         bus.seg_in = rand_illegal();
         wait_valid(20, "t3_rep_wait");
         tick();
      end
      chk("t3_sat", 32'(bus.err_count), 32'd255);

      // 4: result held while consumer stalls, then the changed pattern follows
      bus.out_ready = 1'b0;
      bus.seg_in    = 7'b0000011;
      wait_valid(20, "t4_wait_b");
      chk("t4_nib_b", 32'(bus.out_nibble), 32'hB);
      bus.seg_in = 7'b0000110;
      repeat (10) tick();
      chk("t4_hold_v", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_b", 32'(bus.out_nibble), 32'hB);
      bus.out_ready = 1'b1;
      tick();
      wait_valid(20, "t4_wait_e");
      chk("t4_nib_e", 32'(bus.out_nibble), 32'hE);
      tick();

      // 5: toggling never stabilises; blank stabilises but never emits
      for (int i = 0; i < 12; i++) begin
         bus.seg_in = i[0] ? 7'b0100100 : 7'b1111001;
         tick();
         chk("t5_stable", 32'(bus.stable), 32'd0);
         chk("t5_valid", 32'(bus.out_valid), 32'd0);
      end
      bus.seg_in = 7'h7F;
      repeat (8) begin
         tick();
         chk("t5_blank_v", 32'(bus.out_valid), 32'd0);
      end
      chk("t5_blank_s", 32'(bus.stable), 32'd1);

      // 6: asynchronous reset mid-offer clears outputs at once, then recapture
      bus.out_ready = 1'b0;
      bus.seg_in    = 7'b0100100;
      wait_valid(20, "t6_wait");
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("t6_valid", 32'(bus.out_valid), 32'd0);
      chk("t6_stable", 32'(bus.stable), 32'd0);
      chk("t6_errcnt", 32'(bus.err_count), 32'd0);
      @(negedge clk);
      reset         = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) tick();
      chk("t6_early", 32'(bus.out_valid), 32'd0);
      tick();
      chk("t6_recap", 32'(bus.out_valid), 32'd1);
      chk("t6_nib", 32'(bus.out_nibble), 32'h2);

      // Randomized segments with random enables and consumer stalls
      for (int seg_i = 0; seg_i < 120; seg_i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7)       bus.seg_in = seg_tab[$urandom_range(0, 15)];
         else if (r == 7) bus.seg_in = 7'h7F;
         else             bus.seg_in = rand_illegal();
         hold = int'($urandom_range(1, 9));
         for (int k = 0; k < hold; k++) begin
            bus.sample_en = ($urandom_range(0, 4) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
- Inverse of the team's hex-to-seven-segment drivers: takes an active-low 7-segment pattern (bit0 = segment a … bit6 = segment g) and recovers the 4-bit hex digit.
- Filters the pattern for stability and emits each distinct stable digit once over a valid/ready handshake.
- Flags illegal patterns and keeps a saturating error count.
- Consumers are ALU operand loaders and bench checkers that read back HEX outputs.

Parameters:
STABLE_CYCLES, 4, number of consecutive rising edges seg_in must hold one value before it is decoded (legal range 2..15)
ERR_W, 8, width of err_count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
seg_in  input  7  active-low segment pattern; bit0=a … bit6=g
sample_en  input  1  allows a new capture from IDLE
out_ready  input  1  consumer accepts out_nibble/out_err
out_valid  output  1  decoded result available
out_nibble  output  4  decoded hex digit; 0 when out_err=1
out_err  output  1  captured pattern is not in the legal table
stable  output  1  seg_in has met the STABLE_CYCLES requirement
err_count  output  ERR_W  saturating count of accepted error results

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-high.
  - Reset values: out_valid=0, out_nibble=0, out_err=0, stable=0, err_count=0, FSM=IDLE, internal prev-sample register p=7'h7F, stability counter cnt=0.
  - Reset asserted mid-operation aborts any pending result immediately; no handshake completes.
- Stability filter (runs every cycle, in every state):
  - p <= seg_in.
  - If seg_in != p: cnt <= 1.
  - Else: cnt <= min(cnt+1, STABLE_CYCLES).
  - stable = (cnt == STABLE_CYCLES), combinational from cnt.
- Legal table (active-low, bits g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Blank = 1111111; it is not a digit and is never emitted.
  - Any other pattern is an error.
- FSM states:
  - IDLE:
    - If stable && sample_en && p != 7'h7F: register decode of p into out_nibble/out_err, set out_valid=1, go to EMIT.
    - Otherwise stay in IDLE.
  - EMIT:
    - out_valid=1. out_nibble and out_err are held constant even if seg_in changes.
    - On out_valid && out_ready: clear out_valid, increment err_count if out_err (saturate at all-ones), go to WAIT_CHG.
  - WAIT_CHG:
    - When cnt != STABLE_CYCLES (the pattern changed), go to IDLE.
    - Each distinct stable pattern is therefore emitted once. The same digit is emitted again only after the pattern changes and then re-stabilises.
- Latency:
  - Condition: a new pattern is applied before edge E0, FSM is in IDLE, sample_en=1.
  - cnt reaches STABLE_CYCLES at edge E(STABLE_CYCLES-1).
  - out_valid rises at edge E(STABLE_CYCLES). With the default of 4, that is 5 edges counting E0.
- Boundary conditions:
  - sample_en=0 in IDLE: no capture; the stable pattern waits and is captured when sample_en rises.
  - sample_en dropping during EMIT or WAIT_CHG has no effect.
  - out_ready=1 in the same cycle out_valid first rises: the handshake completes on the next edge, so out_valid is high for exactly 1 cycle.
  - seg_in toggling every cycle: cnt never exceeds 1; no output.
  - A pattern change during EMIT makes WAIT_CHG exit to IDLE immediately after the handshake.
  - err_count holds at 2^ERR_W-1.

Test Plan:
1. Reset, then hold seg_in=7'b0100100, sample_en=1, out_ready=1 -> out_valid=1 for one cycle at edge E4, out_nibble=2, out_err=0, err_count=0.
2. seg_in=7'b0001110 held 20 cycles with out_ready=1 -> exactly one emission, out_nibble=F; change to 7'b1000000 -> a second emission, out_nibble=0.
3. seg_in=7'b1010101 (illegal) held, out_ready=1 -> out_err=1, out_nibble=0, err_count=1; repeat the sequence 300 times with ERR_W=8 -> err_count saturates at 255.
4. out_ready=0, seg_in=7'b0000011 stable, then seg_in changes to 7'b0000110 while out_valid=1 -> out_nibble stays 0xB until out_ready=1; the next emission is 0xE.
5. seg_in alternating 7'b1111001/7'b0100100 every cycle -> stable=0 throughout, out_valid never asserts; seg_in=7'h7F held -> stable=1 but no emission.
6. Assert reset asynchronously mid-EMIT (between edges) -> out_valid, stable, and err_count go to 0 immediately; FSM returns to IDLE and re-captures after STABLE_CYCLES+1 edges once reset is released.
